// File: rtl/ctx_stack_pkg.sv
// Shared definitions for the context stack: frame geometry, FSM encoding and
// the frame-slot layout used on the 9-word push/pop bus.
package ctx_stack_pkg;

    localparam int FRAME_WORDS = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP_RD,
        ST_POP_DONE
    } state_e;

    localparam int SLOT_ACC = 0;
    localparam int SLOT_R0  = 1;
    localparam int SLOT_R1  = 2;
    localparam int SLOT_R2  = 3;
    localparam int SLOT_R3  = 4;
    localparam int SLOT_R4  = 5;
    localparam int SLOT_R5  = 6;
    localparam int SLOT_R6  = 7;
    localparam int SLOT_R7  = 8;

    // Word address of one slot within a stored frame.
    function automatic int frame_addr(input int frame, input int slot);
        return frame * FRAME_WORDS + slot;
    endfunction

endpackage

// File: rtl/ctx_stack_mem.sv
// Single-port frame RAM: synchronous write, synchronous read with one cycle
// of latency (read returns the old word when written in the same cycle).
module ctx_stack_mem #(
    parameter int WIDTH  = 8,
    parameter int WORDS  = 36,
    parameter int ADDR_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    // NOTE: storage has no reset; a frame is only read after it was written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ctx_stack.sv
// LIFO of register-file frames (ACC, R0..R7). Push writes a captured frame one
// word per cycle; pop reads it back, loads the pop bus and strobes stk_pop_we.
module ctx_stack
    import ctx_stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stk_push_req,
    input  logic                       stk_pop_req,
    input  logic [WIDTH-1:0]           stk_push1,
    input  logic [WIDTH-1:0]           stk_push2,
    input  logic [WIDTH-1:0]           stk_push3,
    input  logic [WIDTH-1:0]           stk_push4,
    input  logic [WIDTH-1:0]           stk_push5,
    input  logic [WIDTH-1:0]           stk_push6,
    input  logic [WIDTH-1:0]           stk_push7,
    input  logic [WIDTH-1:0]           stk_push8,
    input  logic [WIDTH-1:0]           stk_push9,
    output logic [WIDTH-1:0]           stk_pop1,
    output logic [WIDTH-1:0]           stk_pop2,
    output logic [WIDTH-1:0]           stk_pop3,
    output logic [WIDTH-1:0]           stk_pop4,
    output logic [WIDTH-1:0]           stk_pop5,
    output logic [WIDTH-1:0]           stk_pop6,
    output logic [WIDTH-1:0]           stk_pop7,
    output logic [WIDTH-1:0]           stk_pop8,
    output logic [WIDTH-1:0]           stk_pop9,
    output logic                       stk_pop_we,
    output logic                       stk_busy,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       stk_ovf,
    output logic                       stk_unf,
    output logic [$clog2(DEPTH+1)-1:0] stk_level
);

    localparam int          LVL_W     = $clog2(DEPTH + 1);
    localparam int          MEM_WORDS = DEPTH * FRAME_WORDS;
    localparam int          ADDR_W    = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAST_SLOT = 4'(FRAME_WORDS - 1);
    localparam logic [3:0]  POP_END   = 4'(FRAME_WORDS);

    state_e           state;
    logic [3:0]       idx;
    logic [LVL_W-1:0] level;
    logic             rd_vld;
    logic [3:0]       rd_idx;

    logic [WIDTH-1:0] push_w [FRAME_WORDS];
    logic [WIDTH-1:0] snap   [FRAME_WORDS];
    logic [WIDTH-1:0] pop_r  [FRAME_WORDS];

    logic             push_go;
    logic             mem_we;
    logic [LVL_W-1:0] frame;
    logic [3:0]       slot;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0] mem_rdata;

    assign push_w[SLOT_ACC] = stk_push1;
    assign push_w[SLOT_R0]  = stk_push2;
    assign push_w[SLOT_R1]  = stk_push3;
    assign push_w[SLOT_R2]  = stk_push4;
    assign push_w[SLOT_R3]  = stk_push5;
    assign push_w[SLOT_R4]  = stk_push6;
    assign push_w[SLOT_R5]  = stk_push7;
    assign push_w[SLOT_R6]  = stk_push8;
    assign push_w[SLOT_R7]  = stk_push9;

    assign stk_full  = (level == LVL_W'(DEPTH));
    assign stk_empty = (level == '0);
    assign stk_level = level;
    assign push_go   = (state == ST_IDLE) && stk_push_req && !stk_full;

    // NOTE: every always_comb output gets a value on every path, so no latches.
    always_comb begin
        mem_we   = (state == ST_PUSH);
        frame    = (state == ST_PUSH) ? level : level - 1'b1;
        slot     = (idx > LAST_SLOT) ? LAST_SLOT : idx;
        mem_addr = ADDR_W'(frame_addr(int'(frame), int'(slot)));
    end

    ctx_stack_mem #(
        .WIDTH (WIDTH),
        .WORDS (MEM_WORDS),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(snap[slot]),
        .rdata(mem_rdata)
    );

    // Frame is frozen at acceptance so the register file may move on meanwhile.
    always_ff @(posedge clk) begin
        if (push_go) begin
            snap <= push_w;
        end
    end

    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            level      <= '0;
            stk_busy   <= 1'b0;
            stk_pop_we <= 1'b0;
            stk_ovf    <= 1'b0;
            stk_unf    <= 1'b0;
            rd_vld     <= 1'b0;
            rd_idx     <= '0;
            for (int i = 0; i < FRAME_WORDS; i++) begin
                pop_r[i] <= '0;
            end
        end else begin
            rd_vld <= 1'b0;
            if (rd_vld) begin
                pop_r[rd_idx] <= mem_rdata;
            end
            case (state)
                ST_IDLE: begin
                    if (push_go) begin
                        state    <= ST_PUSH;
                        idx      <= '0;
                        stk_busy <= 1'b1;
                    end else if (stk_push_req) begin
                        stk_ovf <= 1'b1;
                    end else if (stk_pop_req && !stk_empty) begin
                        state    <= ST_POP_RD;
                        idx      <= '0;
                        stk_busy <= 1'b1;
                    end else if (stk_pop_req) begin
                        stk_unf <= 1'b1;
                    end
                end
                ST_PUSH: begin
                    if (idx == LAST_SLOT) begin
                        level    <= level + 1'b1;
                        state    <= ST_IDLE;
                        stk_busy <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_POP_RD: begin
                    // One extra cycle drains the last read before the strobe.
                    if (idx == POP_END) begin
                        level      <= level - 1'b1;
                        state      <= ST_POP_DONE;
                        stk_pop_we <= 1'b1;
                    end else begin
                        rd_vld <= 1'b1;
                        rd_idx <= idx;
                        idx    <= idx + 1'b1;
                    end
                end
                ST_POP_DONE: begin
                    stk_pop_we <= 1'b0;
                    stk_busy   <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stk_pop1 = pop_r[SLOT_ACC];
    assign stk_pop2 = pop_r[SLOT_R0];
    assign stk_pop3 = pop_r[SLOT_R1];
    assign stk_pop4 = pop_r[SLOT_R2];
    assign stk_pop5 = pop_r[SLOT_R3];
    assign stk_pop6 = pop_r[SLOT_R4];
    assign stk_pop7 = pop_r[SLOT_R5];
    assign stk_pop8 = pop_r[SLOT_R6];
    assign stk_pop9 = pop_r[SLOT_R7];

endmodule
